// File: rtl/uart_rx_byte_if.sv
// rtl/uart_rx_byte_if.sv - serial pin and received-byte signals of uart_rx_byte
interface uart_rx_byte_if;
    logic       uart_data;
    logic [7:0] rx_data;
    logic       rx_dv;
    logic       rx_frame_err;
    logic       rx_busy;
`ifdef UART_RX_PARITY_EN
    logic       rx_parity_err;
`endif

    modport master (
        input  uart_data,
        output rx_data,
        output rx_dv,
        output rx_frame_err,
`ifdef UART_RX_PARITY_EN
        output rx_parity_err,
`endif
        output rx_busy
    );

    modport slave (
        output uart_data,
        input  rx_data,
        input  rx_dv,
        input  rx_frame_err,
`ifdef UART_RX_PARITY_EN
        input  rx_parity_err,
`endif
        input  rx_busy
    );
endinterface

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 UART receiver with framing error pulse; UART_RX_PARITY_EN adds even parity
// rx_dv rises SYNC_STAGES + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 2 clocks after the start edge at the pin.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 104,
    parameter int SYNC_STAGES  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_rx_byte_if.master  ifc
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             data_q, data_d;
    logic                   dv_q, dv_d;
    logic                   ferr_q, ferr_d;
    logic                   rxs;
`ifdef UART_RX_PARITY_EN
    logic                   par_bad_q, par_bad_d;
    logic                   perr_q, perr_d;
`endif

    assign rxs = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            dv_q      <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], ifc.uart_data};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            dv_q      <= dv_d;
            ferr_q    <= ferr_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_d     = bit_q;
        shift_d   = shift_q;
        data_d    = data_q;
        dv_d      = 1'b0;
        ferr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
        perr_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxs) state_d = START;
            end
            START: begin
                // A start bit that is gone by mid-bit was a glitch.
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    par_bad_d = ^{shift_q, rxs};
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rxs) begin
                        // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bad_q) begin
                            perr_d = 1'b1;
                        end else begin
                            dv_d   = 1'b1;
                            data_d = shift_q;
                        end
`else
                        dv_d   = 1'b1;
                        data_d = shift_q;
`endif
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rxs) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign ifc.rx_data       = data_q;
    assign ifc.rx_dv         = dv_q;
    assign ifc.rx_frame_err  = ferr_q;
    assign ifc.rx_busy       = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign ifc.rx_parity_err = perr_q;
`endif
endmodule
